// File: rtl/data_pipeline_decoder.sv
// Purpose : four-stage valid/ready decoder that removes the +6 offset of the forward pipeline.
// Latency : a word accepted at edge N is presented on out_data after edge N+3.
// Backpressure: per-stage; bubbles collapse while stalled, in_ready drops only when all stages hold data.
//
// Ports:
//   clk, rst       - sole clock; synchronous active-high reset (clears valid and data).
//   flush          - synchronous clear of all valid bits; blocks input acceptance that cycle.
//   in_data/in_valid/in_ready    - encoded word input handshake.
//   out_data/out_valid/out_ready - decoded word output handshake (out_data = in_data - 6).
//   occ            - number of occupied stages, only when DEC_PIPE_OCC_EN is defined.
// Optional feature macro: DEC_PIPE_OCC_EN
module data_pipeline_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef DEC_PIPE_OCC_EN
    ,
    output logic [2:0]       occ
`endif
);

    // Per-stage subtraction applied when a stage loads from its predecessor.
    localparam logic [WIDTH-1:0] SUB1 = WIDTH'(3);
    localparam logic [WIDTH-1:0] SUB2 = WIDTH'(2);
    localparam logic [WIDTH-1:0] SUB3 = WIDTH'(1);

    logic [3:0][WIDTH-1:0] d_q, d_d;
    logic [3:0]            v_q, v_d;
    logic [3:0]            adv;
    logic                  load0;

    always_comb begin
        adv = '0;
        // Ready ripples backward from the consumer so a full pipe can advance in one cycle.
        adv[3] = v_q[3] & out_ready;
        for (int k = 2; k >= 0; k--) begin
            adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
        end
    end

    always_comb begin
        in_ready = ~flush & (~v_q[0] | adv[0]);
        load0    = in_valid & in_ready;
    end

    always_comb begin
        d_d = d_q;
        v_d = v_q;

        if (load0) begin
            d_d[0] = in_data;
        end
        if (adv[0]) begin
            d_d[1] = d_q[0] - SUB1;
        end
        if (adv[1]) begin
            d_d[2] = d_q[1] - SUB2;
        end
        if (adv[2]) begin
            d_d[3] = d_q[2] - SUB3;
        end

        // A stage is valid next cycle if it loads, or if it holds and does not advance.
        v_d[0] = load0 | (v_q[0] & ~adv[0]);
        for (int k = 1; k < 4; k++) begin
            v_d[k] = adv[k-1] | (v_q[k] & ~adv[k]);
        end

        // Flush discards in-flight words; data registers are don't-care once invalid.
        if (flush) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
            v_q <= '0;
        end else begin
            d_q <= d_d;
            v_q <= v_d;
        end
    end

    assign out_valid = v_q[3];
    assign out_data  = d_q[3];

`ifdef DEC_PIPE_OCC_EN
    logic [2:0] occ_q;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Tracks popcount of the next valid vector so it always matches v_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= popcnt4(v_d);
        end
    end

    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_data_pipeline_decoder.sv
module tb_data_pipeline_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef DEC_PIPE_OCC_EN
    logic [2:0] occ;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_pipeline_decoder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEC_PIPE_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef DEC_PIPE_OCC_EN
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occ); end
`endif
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        in_data = 8'h10; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b expected 1", in_ready); end
        tick();                       // acceptance edge
        in_valid = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            if (e < 4) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid e%0d: got %b expected 0", e, out_valid); end
            end
            tick();
        end
        // now 4 edges after acceptance: word visible since edge N+3, consumed at N+4
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_drop_valid: got %b expected 0", out_valid); end
    endtask

    // Re-run to observe the N+3 point precisely.
    task automatic test_latency_point();
        out_ready = 1'b1;
        in_data = 8'h10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latpt_n2_valid: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latpt_n3_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 8'h0A) begin errors++; $display("FAIL latpt_n3_data: got %h expected 0a", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latpt_n4_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_stream();
        logic [7:0] ins [4];
        logic [7:0] exp [4];
        ins = '{8'h00, 8'h03, 8'h06, 8'hFF};
        exp = '{8'hFA, 8'hFD, 8'h00, 8'hF9};
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                in_data = ins[c]; in_valid = 1'b1;
                #1;
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c%0d: got %b expected 1", c, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 3 && c <= 6) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid c%0d: got %b expected 1", c, out_valid); end
                checks++; if (out_data !== exp[c-3]) begin errors++; $display("FAIL stream_data c%0d: got %h expected %h", c, out_data, exp[c-3]); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle c%0d: got %b expected 0", c, out_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h20 + 8'(i); in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready i%0d: got %b expected 1", i, in_ready); end
`ifdef DEC_PIPE_OCC_EN
            checks++; if (occ !== 3'(i)) begin errors++; $display("FAIL bp_occ_step i%0d: got %0d expected %0d", i, occ, i); end
`endif
            tick();
        end
        in_data = 8'h24; in_valid = 1'b1;
        for (int h = 0; h < 3; h++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready h%0d: got %b expected 0", h, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h1A) begin errors++; $display("FAIL bp_hold h%0d: got %b/%h expected 1/1a", h, out_valid, out_data); end
`ifdef DEC_PIPE_OCC_EN
            checks++; if (occ !== 3'd4) begin errors++; $display("FAIL bp_occ_full h%0d: got %0d expected 4", h, occ); end
`endif
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        tick();                       // emits 1A, accepts 24
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h1B + 8'(k)) begin errors++; $display("FAIL bp_drain k%0d: got %b/%h expected 1/%h", k, out_valid, out_data, 8'h1B + 8'(k)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
`ifdef DEC_PIPE_OCC_EN
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL bp_occ_drained: got %0d expected 0", occ); end
`endif
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h40 + 8'(i); in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            in_data = 8'h44 + 8'(j); in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready j%0d: got %b expected 1", j, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h3A + 8'(j)) begin errors++; $display("FAIL b2b_out j%0d: got %b/%h expected 1/%h", j, out_valid, out_data, 8'h3A + 8'(j)); end
`ifdef DEC_PIPE_OCC_EN
            checks++; if (occ !== 3'd4) begin errors++; $display("FAIL b2b_occ j%0d: got %0d expected 4", j, occ); end
`endif
            tick();
        end
        in_valid = 1'b0;
        for (int j = 8; j < 12; j++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h3A + 8'(j)) begin errors++; $display("FAIL b2b_drain j%0d: got %b/%h expected 1/%h", j, out_valid, out_data, 8'h3A + 8'(j)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h50 + 8'(i); in_valid = 1'b1;
            tick();
        end
        flush = 1'b1; in_data = 8'h99; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %b expected 1", in_ready); end
`ifdef DEC_PIPE_OCC_EN
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL flush_occ: got %0d expected 0", occ); end
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost c%0d: got %b/%h expected 0", c, out_valid, out_data); end
        end
        // First word after flush sees the full latency.
        in_data = 8'h60; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_relat_early: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin errors++; $display("FAIL flush_relat: got %b/%h expected 1/5a", out_valid, out_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h70 + 8'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h6A) begin errors++; $display("FAIL rst_pre_full: got %b/%h expected 1/6a", out_valid, out_data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready); end
`ifdef DEC_PIPE_OCC_EN
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL rst_mid_occ: got %0d expected 0", occ); end
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ghost c%0d: got %b/%h expected 0", c, out_valid, out_data); end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        test_reset();
        test_latency();
        test_latency_point();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
